// File: rtl/iiq_pkg.sv
// Shared integer issue queue types: entry layout, field widths and the
// derived flat entry width used on the queue-facing buses.
package iiq_pkg;

  localparam int IIQ_TAG_WIDTH     = 6;
  localparam int IIQ_PAYLOAD_WIDTH = 32;

  typedef struct packed {
    logic                         vld;
    logic                         s1_rdy;
    logic [IIQ_TAG_WIDTH-1:0]     s1_tag;
    logic                         s2_rdy;
    logic [IIQ_TAG_WIDTH-1:0]     s2_tag;
    logic [IIQ_TAG_WIDTH-1:0]     dst_tag;
    logic [IIQ_PAYLOAD_WIDTH-1:0] payload;
  } iiq_entry_t;

  function automatic int entry_width(input int tag_w, input int payload_w);
    return 1 + 2 * (1 + tag_w) + tag_w + payload_w;
  endfunction

endpackage

// File: rtl/oldest_pick_onehot.sv
// Lowest-index-set one-hot picker; index 0 holds the oldest entry in the
// compacting issue queues, so this selects the oldest requester.
module oldest_pick_onehot #(
  parameter int N = 8
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);

  // Two's-complement trick isolates the least significant set bit.
  assign o_gnt = i_req & (~i_req + N'(1));

endmodule

// File: rtl/iiq_issue_select.sv
// IIQ wakeup, oldest-ready select and issue pipeline register feeding the
// integer execute stage.
module iiq_issue_select
  import iiq_pkg::*;
#(
  parameter int N_ENTRIES     = 8,
  parameter int TAG_WIDTH     = IIQ_TAG_WIDTH,
  parameter int PAYLOAD_WIDTH = IIQ_PAYLOAD_WIDTH,
  parameter int N_WB          = 2,
  localparam int ENTRY_WIDTH  = entry_width(TAG_WIDTH, PAYLOAD_WIDTH)
) (
  input  logic                             clk,
  input  logic                             rst_aL,
  input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts,
  output logic                             deq_ready,
  output logic [N_ENTRIES-1:0]             deq_sel_onehot,
  input  logic [ENTRY_WIDTH-1:0]           deq_data,
  output logic [N_ENTRIES-1:0]             wr_en,
  output logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data,
  input  logic [N_WB-1:0]                  wb_valid,
  input  logic [N_WB*TAG_WIDTH-1:0]        wb_tag,
  input  logic                             flush,
  output logic                             iss_valid,
  input  logic                             iss_ready,
  output logic [ENTRY_WIDTH-1:0]           iss_data,
  output logic [31:0]                      iss_count
);

  iiq_entry_t                           w_entry [N_ENTRIES];
  logic [N_ENTRIES-1:0][N_WB-1:0]       w_s1_hit;
  logic [N_ENTRIES-1:0][N_WB-1:0]       w_s2_hit;
  logic [N_ENTRIES-1:0]                 w_s1_match;
  logic [N_ENTRIES-1:0]                 w_s2_match;
  logic [N_ENTRIES-1:0]                 w_elig;
  logic [N_ENTRIES-1:0]                 w_oldest;
  logic [N_ENTRIES-1:0]                 w_deq_sel;
  logic                                 w_pick_en;
  logic                                 w_pick_s1;
  logic                                 w_pick_s2;
  iiq_entry_t                           w_deq_entry;
  iiq_entry_t                           w_iss_next;

  logic                                 r_iss_vld;
  logic [ENTRY_WIDTH-1:0]               r_iss_data;
  logic [31:0]                          r_iss_count;

  for (genvar i = 0; i < N_ENTRIES; i++) begin : g_entry
    iiq_entry_t w_upd;

    assign w_entry[i] = iiq_entry_t'(entry_douts[i*ENTRY_WIDTH +: ENTRY_WIDTH]);

    // Tag 0 means "no register" and must never wake a source.
    for (genvar p = 0; p < N_WB; p++) begin : g_port
      assign w_s1_hit[i][p] = wb_valid[p] && w_entry[i].vld && !w_entry[i].s1_rdy &&
                              (w_entry[i].s1_tag != '0) &&
                              (wb_tag[p*TAG_WIDTH +: TAG_WIDTH] == w_entry[i].s1_tag);
      assign w_s2_hit[i][p] = wb_valid[p] && w_entry[i].vld && !w_entry[i].s2_rdy &&
                              (w_entry[i].s2_tag != '0) &&
                              (wb_tag[p*TAG_WIDTH +: TAG_WIDTH] == w_entry[i].s2_tag);
    end

    assign w_s1_match[i] = |w_s1_hit[i];
    assign w_s2_match[i] = |w_s2_hit[i];
    assign w_elig[i]     = w_entry[i].vld &
                           (w_entry[i].s1_rdy | w_s1_match[i]) &
                           (w_entry[i].s2_rdy | w_s2_match[i]);

    assign w_upd = {w_entry[i].vld,
                    w_entry[i].s1_rdy | w_s1_match[i], w_entry[i].s1_tag,
                    w_entry[i].s2_rdy | w_s2_match[i], w_entry[i].s2_tag,
                    w_entry[i].dst_tag, w_entry[i].payload};

    // The picked entry leaves the queue this cycle, so no write-back for it.
    assign wr_en[i] = (w_s1_match[i] | w_s2_match[i]) & ~w_deq_sel[i];
    assign wr_data[i*ENTRY_WIDTH +: ENTRY_WIDTH] = w_upd;
  end

  oldest_pick_onehot #(.N(N_ENTRIES)) u_pick (
    .i_req (w_elig),
    .o_gnt (w_oldest)
  );

  // Issue handshake: iss_data is held stable while iss_valid & ~iss_ready;
  // the op is consumed on a cycle with iss_valid & iss_ready, and a new op
  // may be loaded in that same cycle.
  assign deq_ready      = ~r_iss_vld | iss_ready;
  assign w_pick_en      = deq_ready & ~flush;
  assign w_deq_sel      = w_oldest & {N_ENTRIES{w_pick_en}};
  assign deq_sel_onehot = w_deq_sel;

  assign w_pick_s1   = |(w_deq_sel & w_s1_match);
  assign w_pick_s2   = |(w_deq_sel & w_s2_match);
  assign w_deq_entry = iiq_entry_t'(deq_data);
  assign w_iss_next  = {w_deq_entry.vld,
                        w_deq_entry.s1_rdy | w_pick_s1, w_deq_entry.s1_tag,
                        w_deq_entry.s2_rdy | w_pick_s2, w_deq_entry.s2_tag,
                        w_deq_entry.dst_tag, w_deq_entry.payload};

  always_ff @(posedge clk) begin
    if (!rst_aL) begin
      r_iss_vld   <= 1'b0;
      r_iss_data  <= '0;
      r_iss_count <= '0;
    end else begin
      if (r_iss_vld && iss_ready) r_iss_count <= r_iss_count + 32'd1;
      if (flush) begin
        r_iss_vld <= 1'b0;
      end else if (|w_deq_sel) begin
        r_iss_vld  <= 1'b1;
        r_iss_data <= w_iss_next;
      end else if (iss_ready) begin
        r_iss_vld <= 1'b0;
      end
    end
  end

  assign iss_valid = r_iss_vld;
  assign iss_data  = r_iss_data;
  assign iss_count = r_iss_count;

endmodule

// File: tb/tb_iiq_issue_select.sv
// Directed bench for iiq_issue_select: the bench plays the queue, drives
// writebacks and the execute-side handshake, and checks against hand values.
module tb_iiq_issue_select;
  import iiq_pkg::*;

  localparam int N  = 8;
  localparam int EW = entry_width(IIQ_TAG_WIDTH, IIQ_PAYLOAD_WIDTH);

  logic            clk;
  logic            rst_aL;
  logic [N*EW-1:0] entry_douts;
  logic            deq_ready;
  logic [N-1:0]    deq_sel_onehot;
  logic [EW-1:0]   deq_data;
  logic [N-1:0]    wr_en;
  logic [N*EW-1:0] wr_data;
  logic [1:0]      wb_valid;
  logic [11:0]     wb_tag;
  logic            flush;
  logic            iss_valid;
  logic            iss_ready;
  logic [EW-1:0]   iss_data;
  logic [31:0]     iss_count;

  iiq_entry_t q [N];
  int checks;
  int errors;
  logic [31:0] exp_count;

  iiq_issue_select dut (
    .clk            (clk),
    .rst_aL         (rst_aL),
    .entry_douts    (entry_douts),
    .deq_ready      (deq_ready),
    .deq_sel_onehot (deq_sel_onehot),
    .deq_data       (deq_data),
    .wr_en          (wr_en),
    .wr_data        (wr_data),
    .wb_valid       (wb_valid),
    .wb_tag         (wb_tag),
    .flush          (flush),
    .iss_valid      (iss_valid),
    .iss_ready      (iss_ready),
    .iss_data       (iss_data),
    .iss_count      (iss_count)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    entry_douts = '0;
    for (int i = 0; i < N; i++) entry_douts[i*EW +: EW] = q[i];
  end

  function automatic iiq_entry_t mk(input logic v, input logic s1r, input logic [5:0] s1t,
                                    input logic s2r, input logic [5:0] s2t,
                                    input logic [5:0] dt, input logic [31:0] pl);
    iiq_entry_t e;
    e.vld = v; e.s1_rdy = s1r; e.s1_tag = s1t;
    e.s2_rdy = s2r; e.s2_tag = s2t; e.dst_tag = dt; e.payload = pl;
    return e;
  endfunction

  // ---------------- drivers ----------------
  task automatic clear_q();
    for (int i = 0; i < N; i++) q[i] = '0;
    deq_data = '0;
    wb_valid = '0;
    wb_tag   = '0;
  endtask

  task automatic idle();
    clear_q();
    flush     = 1'b0;
    iss_ready = 1'b1;
    if (iss_valid) exp_count = exp_count + 32'd1;
    @(posedge clk); #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_aL = 1'b0; flush = 1'b0; iss_ready = 1'b0;
    clear_q();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL reset_iss_valid got %b exp 0", iss_valid); end
    checks++; if (iss_data !== '0) begin errors++; $display("FAIL reset_iss_data got %h exp 0", iss_data); end
    checks++; if (iss_count !== 32'd0) begin errors++; $display("FAIL reset_iss_count got %0d exp 0", iss_count); end
    checks++; if (deq_sel_onehot !== 8'h00) begin errors++; $display("FAIL reset_deq_sel got %b exp 0", deq_sel_onehot); end
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
    rst_aL = 1'b1;
    exp_count = 32'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_pick_oldest();
    iiq_entry_t e1;
    clear_q();
    q[0] = mk(1, 0, 6'd5, 1, 6'd0, 6'd10, 32'h0000_00A0);
    q[1] = mk(1, 1, 6'd0, 1, 6'd0, 6'd11, 32'h0000_00A1);
    q[3] = mk(1, 1, 6'd0, 1, 6'd0, 6'd13, 32'h0000_00A3);
    e1 = q[1];
    deq_data  = q[1];
    iss_ready = 1'b1;
    @(negedge clk);
    checks++; if (deq_sel_onehot !== 8'b0000_0010) begin errors++; $display("FAIL pick_sel got %b exp 00000010", deq_sel_onehot); end
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL pick_wr_en got %b exp 0", wr_en); end
    @(posedge clk); #1;
    clear_q();
    checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL pick_iss_valid got %b exp 1", iss_valid); end
    checks++; if (iss_data !== e1) begin errors++; $display("FAIL pick_iss_data got %h exp %h", iss_data, e1); end
    idle();
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL pick_count got %0d exp %0d", iss_count, exp_count); end
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL pick_drain got %b exp 0", iss_valid); end
  endtask

  // Leaves iss_valid=1 holding the bypassed entry 0 for the stall scenario.
  task automatic test_bypass(output iiq_entry_t held);
    clear_q();
    q[0] = mk(1, 0, 6'd5, 1, 6'd0, 6'd10, 32'h0000_00A0);
    q[1] = mk(1, 1, 6'd0, 1, 6'd0, 6'd11, 32'h0000_00A1);
    q[3] = mk(1, 1, 6'd0, 1, 6'd0, 6'd13, 32'h0000_00A3);
    deq_data = q[0];
    wb_valid = 2'b01;
    wb_tag   = {6'd0, 6'd5};
    held = q[0];
    held.s1_rdy = 1'b1;
    @(negedge clk);
    checks++; if (deq_sel_onehot !== 8'b0000_0001) begin errors++; $display("FAIL bypass_sel got %b exp 00000001", deq_sel_onehot); end
    checks++; if (wr_en !== 8'h00) begin errors++; $display("FAIL bypass_wr_en got %b exp 0", wr_en); end
    @(posedge clk); #1;
    checks++; if (iss_data !== held) begin errors++; $display("FAIL bypass_iss_data got %h exp %h", iss_data, held); end
  endtask

  task automatic test_stall(input iiq_entry_t held);
    iiq_entry_t e1;
    clear_q();
    q[1] = mk(1, 1, 6'd0, 1, 6'd0, 6'd11, 32'h0000_00A1);
    e1 = q[1];
    deq_data  = q[1];
    iss_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (deq_sel_onehot !== 8'h00) begin errors++; $display("FAIL stall_sel cyc %0d got %b exp 0", c, deq_sel_onehot); end
      checks++; if (iss_valid !== 1'b1) begin errors++; $display("FAIL stall_valid cyc %0d got %b exp 1", c, iss_valid); end
      checks++; if (iss_data !== held) begin errors++; $display("FAIL stall_data cyc %0d got %h exp %h", c, iss_data, held); end
      @(posedge clk); #1;
    end
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL stall_count_hold got %0d exp %0d", iss_count, exp_count); end
    iss_ready = 1'b1;
    @(negedge clk);
    checks++; if (deq_sel_onehot !== 8'b0000_0010) begin errors++; $display("FAIL release_sel got %b exp 00000010", deq_sel_onehot); end
    @(posedge clk); #1;
    exp_count = exp_count + 32'd1;
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL release_count got %0d exp %0d", iss_count, exp_count); end
    checks++; if (iss_valid !== 1'b1 || iss_data !== e1) begin errors++; $display("FAIL release_next got v=%b %h exp v=1 %h", iss_valid, iss_data, e1); end
    idle();
  endtask

  task automatic test_dual_wakeup();
    iiq_entry_t e2, e4;
    clear_q();
    q[0] = mk(1, 1, 6'd0, 1, 6'd0, 6'd20, 32'h0000_00B0);
    q[2] = mk(1, 0, 6'd7, 0, 6'd9, 6'd22, 32'h0000_00B2);
    deq_data = q[0];
    wb_valid = 2'b11;
    wb_tag   = {6'd9, 6'd7};
    e2 = q[2]; e2.s1_rdy = 1'b1; e2.s2_rdy = 1'b1;
    @(negedge clk);
    checks++; if (wr_en !== 8'b0000_0100) begin errors++; $display("FAIL dual_wr_en got %b exp 00000100", wr_en); end
    checks++; if (wr_data[2*EW +: EW] !== e2) begin errors++; $display("FAIL dual_wr_data got %h exp %h", wr_data[2*EW +: EW], e2); end
    checks++; if (deq_sel_onehot !== 8'b0000_0001) begin errors++; $display("FAIL dual_sel got %b exp 00000001", deq_sel_onehot); end
    // Same port wakes both sources of entry 4; tag 0 on port 1 wakes nothing.
    clear_q();
    q[4] = mk(1, 0, 6'd12, 0, 6'd12, 6'd24, 32'h0000_00B4);
    q[5] = mk(1, 0, 6'd0, 1, 6'd0, 6'd25, 32'h0000_00B5);
    deq_data = q[4];
    e4 = q[4]; e4.s1_rdy = 1'b1; e4.s2_rdy = 1'b1;
    wb_valid = 2'b11;
    wb_tag   = {6'd0, 6'd12};
    flush    = 1'b1;
    #1;
    checks++; if (wr_en !== 8'b0001_0000) begin errors++; $display("FAIL same_port_wr_en got %b exp 00010000", wr_en); end
    checks++; if (wr_data[4*EW +: EW] !== e4) begin errors++; $display("FAIL same_port_wr_data got %h exp %h", wr_data[4*EW +: EW], e4); end
    checks++; if (deq_sel_onehot !== 8'h00) begin errors++; $display("FAIL flush_gates_sel got %b exp 0", deq_sel_onehot); end
    flush = 1'b0;
    #1;
    checks++; if (deq_sel_onehot !== 8'b0001_0000) begin errors++; $display("FAIL same_port_sel got %b exp 00010000", deq_sel_onehot); end
    @(posedge clk); #1;
    checks++; if (iss_data !== e4) begin errors++; $display("FAIL same_port_iss_data got %h exp %h", iss_data, e4); end
    idle();
  endtask

  task automatic test_flush();
    clear_q();
    q[0] = mk(1, 1, 6'd0, 1, 6'd0, 6'd30, 32'h0000_00C0);
    deq_data  = q[0];
    iss_ready = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1;
    @(negedge clk);
    checks++; if (deq_sel_onehot !== 8'h00) begin errors++; $display("FAIL flush_sel got %b exp 0", deq_sel_onehot); end
    @(posedge clk); #1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %b exp 0", iss_valid); end
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL flush_count got %0d exp %0d", iss_count, exp_count); end
    flush = 1'b0;
    @(posedge clk); #1;
    flush = 1'b1; iss_ready = 1'b1;
    @(posedge clk); #1;
    exp_count = exp_count + 32'd1;
    checks++; if (iss_valid !== 1'b0) begin errors++; $display("FAIL flush_rdy_valid got %b exp 0", iss_valid); end
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL flush_rdy_count got %0d exp %0d", iss_count, exp_count); end
    flush = 1'b0;
    idle();
  endtask

  task automatic test_empty_and_reset();
    clear_q();
    wb_valid = 2'b11;
    wb_tag   = {6'd4, 6'd3};
    @(negedge clk);
    checks++; if (deq_sel_onehot !== 8'h00 || wr_en !== 8'h00) begin errors++; $display("FAIL empty got sel %b wr_en %b exp 0 0", deq_sel_onehot, wr_en); end
    clear_q();
    q[0] = mk(1, 1, 6'd0, 1, 6'd0, 6'd31, 32'h0000_00D0);
    deq_data  = q[0];
    iss_ready = 1'b0;
    @(posedge clk); #1;
    clear_q();
    rst_aL = 1'b0;
    @(posedge clk); #1;
    exp_count = 32'd0;
    checks++; if (iss_valid !== 1'b0 || iss_data !== '0) begin errors++; $display("FAIL midstall_reset got v=%b %h exp v=0 0", iss_valid, iss_data); end
    checks++; if (iss_count !== exp_count) begin errors++; $display("FAIL midstall_reset_count got %0d exp 0", iss_count); end
    rst_aL = 1'b1;
    @(posedge clk); #1;
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    iiq_entry_t held;
    checks = 0; errors = 0; exp_count = 32'd0;
    test_reset();
    test_pick_oldest();
    test_bypass(held);
    test_stall(held);
    test_dual_wakeup();
    test_flush();
    test_empty_and_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
